// File: rtl/mp_cache_data_arbiter.sv
// mp_cache_data_arbiter: port-0 owner of the cache data SRAM, zero-fills it after reset and arbitrates core/mem accesses
module mp_cache_data_arbiter #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 256,
  parameter int NUM_WMASKS   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [NUM_WMASKS-1:0] core_wmask,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [NUM_WMASKS-1:0] mem_wmask,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_gnt,
  output logic                  mem_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {INIT, CLOSE, RUN} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [SW-1:0]         starve_cnt;
  logic                  last_wr;
  logic [ADDR_WIDTH-1:0] last_wr_addr;
  logic                  run;
  logic                  core_ok;
  logic                  mem_ok;
  logic                  wr;
  assign run       = state == RUN;
  assign init_done = run;
  assign rdata     = sram_dout0;
  assign core_ok   = core_req && !(last_wr && !core_we && core_addr == last_wr_addr);
  assign mem_ok    = mem_req && !(last_wr && !mem_we && mem_addr == last_wr_addr);
  assign core_gnt  = run && core_ok && (starve_cnt == SW'(STARVE_LIMIT) || !mem_ok);
  assign mem_gnt   = run && mem_ok && !core_gnt;
  assign wr        = core_gnt ? core_we : mem_gnt && mem_we;
  always_comb begin
    sram_csb0   = !(!run || core_gnt || mem_gnt || last_wr);
    sram_web0   = state == INIT ? 1'b0 : core_gnt ? !core_we : mem_gnt ? !mem_we : 1'b1;
    sram_addr0  = !run ? idx : core_gnt ? core_addr : mem_gnt ? mem_addr : last_wr_addr;
    sram_wmask0 = state == INIT ? '1 : core_gnt ? core_wmask : mem_gnt ? mem_wmask : '0;
    sram_din0   = core_gnt ? core_wdata : mem_gnt ? mem_wdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      idx          <= '0;
      starve_cnt   <= '0;
      core_rvalid  <= 1'b0;
      mem_rvalid   <= 1'b0;
      last_wr      <= 1'b0;
      last_wr_addr <= '0;
    end else begin
      state        <= state == INIT ? (&idx ? CLOSE : INIT) : RUN;
      idx          <= state == INIT && !(&idx) ? idx + 1'b1 : idx;
      core_rvalid  <= core_gnt && !core_we;
      mem_rvalid   <= mem_gnt && !mem_we;
      last_wr      <= wr;
      last_wr_addr <= wr ? (core_gnt ? core_addr : mem_addr) : last_wr_addr;
      starve_cnt   <= run && core_req && !core_gnt ?
                      (starve_cnt == SW'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
    end
  end
endmodule

// File: tb/tb_mp_cache_data_arbiter.sv
// tb_mp_cache_data_arbiter: randomized and directed checks of the data arbiter against a bench-side model and SRAM
module tb_mp_cache_data_arbiter;
  localparam int AW = 4;
  localparam int DW = 256;
  localparam int NW = 32;
  localparam int LIM = 4;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done;
  logic          core_req = 1'b0, core_we = 1'b0, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr = '0;
  logic [NW-1:0] core_wmask = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          mem_req = 1'b0, mem_we = 1'b0, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr = '0;
  logic [NW-1:0] mem_wmask = '0;
  logic [DW-1:0] mem_wdata = '0;
  logic [DW-1:0] rdata;
  logic          sram_csb0, sram_web0;
  logic [AW-1:0] sram_addr0;
  logic [NW-1:0] sram_wmask0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0 = '0;
  logic [DW-1:0] sram [16];
  int            checks = 0, errors = 0;
  always #5 clk = ~clk;
  mp_cache_data_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wmask(core_wmask),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .rdata(rdata), .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
    .sram_wmask0(sram_wmask0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [NW-1:0] m);
    logic [DW-1:0] r = old;
    for (int b = 0; b < NW; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction
  always @(posedge clk) begin
    if (!sram_csb0) begin
      if (!sram_web0) sram[sram_addr0] <= merge(sram[sram_addr0], sram_din0, sram_wmask0);
      sram_dout0 <= sram[sram_addr0];
    end
  end
  task automatic chk(input string n, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  int            m_cyc = 0, m_starve = 0;
  bit            m_lw = 0, e_crv = 0, e_mrv = 0, c_took = 0, m_took = 0;
  logic [AW-1:0] m_lwa = '0;
  logic [DW-1:0] e_rd = '0;
  logic [DW-1:0] shadow [16];
  always @(negedge clk) begin : model
    bit ce, me, gc, gm;
    if (!rst_n) begin
      m_cyc = 0; m_starve = 0; m_lw = 0; e_crv = 0; e_mrv = 0; c_took = 0; m_took = 0;
      chk("rst_init_done", init_done, 0);
      chk("rst_gnts", {core_gnt, mem_gnt}, 0);
      chk("rst_rvalids", {core_rvalid, mem_rvalid}, 0);
    end else begin
      chk("core_rvalid", core_rvalid, e_crv);
      chk("mem_rvalid", mem_rvalid, e_mrv);
      if (e_crv || e_mrv) chk("rdata", rdata, e_rd);
      chk("init_done", init_done, m_cyc >= 17);
      gc = 0; gm = 0;
      if (m_cyc < 17) begin
        chk("init_gnts", {core_gnt, mem_gnt}, 0);
        chk("init_sram", {sram_csb0, sram_web0, sram_addr0, sram_wmask0},
            m_cyc < 16 ? {1'b0, 1'b0, 4'(m_cyc), 32'hFFFF_FFFF} : {1'b0, 1'b1, 4'hF, 32'h0});
        if (m_cyc < 16) begin
          chk("init_din", sram_din0, 0);
          shadow[m_cyc] = '0;
        end
      end else begin
        ce = core_req && !(m_lw && !core_we && core_addr == m_lwa);
        me = mem_req && !(m_lw && !mem_we && mem_addr == m_lwa);
        gc = ce && (m_starve == LIM || !me);
        gm = me && !gc;
        chk("gnts", {core_gnt, mem_gnt}, {gc, gm});
        if (gc)
          chk("sram_core", {sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_din0},
              {1'b0, !core_we, core_addr, core_wmask, core_wdata});
        else if (gm)
          chk("sram_mem", {sram_csb0, sram_web0, sram_addr0, sram_wmask0, sram_din0},
              {1'b0, !mem_we, mem_addr, mem_wmask, mem_wdata});
        else if (m_lw)
          chk("sram_dummy", {sram_csb0, sram_web0, sram_addr0, sram_wmask0}, {1'b0, 1'b1, m_lwa, 32'h0});
        else
          chk("sram_idle", {sram_csb0, sram_web0, sram_wmask0}, {1'b1, 1'b1, 32'h0});
      end
      e_crv = gc && !core_we;
      e_mrv = gm && !mem_we;
      if (e_crv) e_rd = shadow[core_addr];
      if (e_mrv) e_rd = shadow[mem_addr];
      m_lw = 0;
      if (gc && core_we) begin
        shadow[core_addr] = merge(shadow[core_addr], core_wdata, core_wmask);
        m_lw = 1; m_lwa = core_addr;
      end
      if (gm && mem_we) begin
        shadow[mem_addr] = merge(shadow[mem_addr], mem_wdata, mem_wmask);
        m_lw = 1; m_lwa = mem_addr;
      end
      m_starve = (m_cyc >= 17 && core_req && !gc) ? (m_starve == LIM ? LIM : m_starve + 1) : 0;
      if (m_cyc < 17) m_cyc++;
      c_took = core_gnt;
      m_took = mem_gnt;
    end
  end
  task automatic wait_init();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!init_done && n < 60);
    chk("init_cycles", n, 17);
  endtask
  task automatic access(input bit is_core, input bit we, input logic [AW-1:0] a, input logic [NW-1:0] mk,
                        input logic [DW-1:0] d, output logic [DW-1:0] q, output int lat);
    int n = 0;
    if (is_core) begin core_req = 1; core_we = we; core_addr = a; core_wmask = mk; core_wdata = d; end
    else begin mem_req = 1; mem_we = we; mem_addr = a; mem_wmask = mk; mem_wdata = d; end
    @(negedge clk);
    while (!(is_core ? core_gnt : mem_gnt) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("gnt_timeout", 1, 0);
    lat = n;
    q = '0;
    @(posedge clk);
    #1;
    if (is_core) core_req = 0; else mem_req = 0;
    if (!we) begin
      @(negedge clk);
      chk("rd_latency", is_core ? core_rvalid : mem_rvalid, 1);
      q = rdata;
      @(posedge clk);
      #1;
    end
  endtask
  logic [DW-1:0] q;
  logic [DW-1:0] rnd;
  int            lat;
  initial begin
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    wait_init();
    for (int i = 0; i < 16; i++) begin
      access(1, 0, 4'(i), '0, '0, q, lat);
      chk("zero_fill", q, 0);
    end
    access(0, 1, 4'd5, '1, {32{8'hA5}}, q, lat);
    access(1, 0, 4'd5, '0, '0, q, lat);
    chk("raw_bubble", lat, 1);
    chk("raw_data", q, {32{8'hA5}});
    access(1, 1, 4'd3, 32'h0000_000F, {{7{32'h1234_5678}}, 32'hDEAD_BEEF}, q, lat);
    access(1, 0, 4'd3, '0, '0, q, lat);
    chk("mask_data", q, {224'h0, 32'hDEAD_BEEF});
    core_req = 1; core_we = 0; core_addr = 4'd1;
    mem_req = 1; mem_we = 0; mem_addr = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("starve_pattern", {core_gnt, mem_gnt}, i % 5 == 4 ? 2'b10 : 2'b01);
    end
    @(posedge clk);
    #1;
    core_req = 0; mem_req = 0;
    @(posedge clk);
    #1;
    mem_req = 1; mem_we = 0; mem_addr = 4'd5;
    lat = 0;
    @(negedge clk);
    while (!mem_gnt && lat < 100) begin
      lat++;
      @(negedge clk);
    end
    chk("mid_rst_gnt", mem_gnt, 1);
    @(posedge clk);
    #1;
    mem_req = 0;
    chk("mid_rst_pre_rvalid", mem_rvalid, 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_rvalid", mem_rvalid, 0);
    chk("mid_rst_init_done", init_done, 0);
    @(posedge clk);
    #2 rst_n = 1;
    wait_init();
    access(1, 0, 4'd5, '0, '0, q, lat);
    chk("post_rst_idx5", q, 0);
    access(0, 0, 4'd3, '0, '0, q, lat);
    chk("post_rst_idx3", q, 0);
    for (int c = 0; c < 3000; c++) begin
      if (core_req && c_took) core_req = 0;
      if (mem_req && m_took) mem_req = 0;
      if (!core_req && $urandom_range(0, 2) != 0) begin
        for (int w = 0; w < 8; w++) rnd[32*w +: 32] = $urandom;
        core_req = 1; core_we = 1'($urandom); core_addr = 4'($urandom_range(0, 3));
        core_wmask = $urandom; core_wdata = rnd;
      end
      if (!mem_req && $urandom_range(0, 2) != 0) begin
        for (int w = 0; w < 8; w++) rnd[32*w +: 32] = $urandom;
        mem_req = 1; mem_we = 1'($urandom); mem_addr = 4'($urandom_range(0, 3));
        mem_wmask = $urandom; mem_wdata = rnd;
      end
      @(posedge clk);
      #1;
    end
    core_req = 0; mem_req = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
